// File: rtl/sram_ctrl.sv
// Request/response front-end for the single-port sram macro: clears the array
// after reset, then serves valid/ready read and write requests.
module sram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    init_done_q, init_done_d;
    logic                    accept;
    logic                    mem_we_c;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state, handshake and memory pin decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;
        req_ready   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr    = req_addr;
        mem_wdata   = req_wdata;
        accept      = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we_c  = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_RESP: begin
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // A read accepted while a response drains keeps the FSM in RESP
        accept = req_valid & req_ready;
        if (accept) begin
            mem_we_c = req_we;
            if (req_we) begin
                state_d = ST_IDLE;
            end else begin
                state_d     = ST_RESP;
                rsp_rdata_d = mem_rdata;
            end
        end
    end

    assign mem_we    = mem_we_c & rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule
